// File: rtl/mod_dm_arbiter.sv
// mod_dm_arbiter: shares the single data memory between the pipeline MEM stage (m0) and the
// loader/debug port (m1). One access in flight: IDLE -> ACCESS -> DONE -> IDLE.
// Byte addresses and sizes become a word address, byte enables and lane-replicated store data.
// Loads are returned right-justified and extended. Misaligned or reserved-size requests are
// acknowledged with an error flag and never reach the memory.
// Optional feature macro: DM_ARB_FIXED_PRIO_EN (m0 always wins a tie; default is round-robin).
module mod_dm_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [1:0]        m0_size,
  input  logic              m0_sext,
  input  logic [31:0]       m0_pc,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [1:0]        m1_size,
  input  logic              m1_sext,
  input  logic [31:0]       m1_pc,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_data_in,
  output logic              dm_write,
  output logic [3:0]        BE,
  output logic [31:0]       pc_now,
  input  logic [DATA_W-1:0] dm_data_out
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e state_q, state_d;
  logic   rr_last_q, rr_last_d;

  // Latched access (captured at grant)
  logic              grant_q;
  logic              we_q;
  logic [1:0]        addr_lo_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [DATA_W-1:0] dm_din_q;
  logic [31:0]       pc_q;

  // Winner selection and its request fields
  logic              any_req;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_size;
  logic              sel_sext;
  logic [31:0]       sel_pc;
  logic              sel_mis;
  logic [DATA_W-1:0] sel_rep;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_val;
  logic              grant_now;

  // Arbitration: pick the winner among current requests
  always_comb begin
    any_req = m0_req | m1_req;
`ifdef DM_ARB_FIXED_PRIO_EN
    pick = ~m0_req;
`else
    if (m0_req && m1_req) pick = ~rr_last_q;
    else                  pick = m1_req;
`endif
    sel_we    = pick ? m1_we    : m0_we;
    sel_addr  = pick ? m1_addr  : m0_addr;
    sel_wdata = pick ? m1_wdata : m0_wdata;
    sel_size  = pick ? m1_size  : m0_size;
    sel_sext  = pick ? m1_sext  : m0_sext;
    sel_pc    = pick ? m1_pc    : m0_pc;
    unique case (sel_size)
      2'b00:   sel_mis = 1'b0;
      2'b01:   sel_mis = sel_addr[0];
      2'b10:   sel_mis = |sel_addr[1:0];
      default: sel_mis = 1'b1;
    endcase
    // Store data replicated so every byte lane carries the right-justified operand
    unique case (sel_size)
      2'b00:   sel_rep = {4{sel_wdata[7:0]}};
      2'b01:   sel_rep = {2{sel_wdata[15:0]}};
      default: sel_rep = sel_wdata;
    endcase
    grant_now = (state_q == StIdle) && any_req;
  end

  // Next-state logic and round-robin pointer update
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          rr_last_d = pick;
          state_d   = sel_mis ? StDone : StAccess;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and round-robin registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Load alignment and extension from the memory word
  always_comb begin
    shifted = dm_data_out >> {addr_lo_q, 3'b000};
    unique case (size_q)
      2'b00:   load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Access latch at grant; load result capture at the end of ACCESS
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_lo_q <= 2'b00;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      dm_addr_q <= '0;
      dm_din_q  <= '0;
      pc_q      <= '0;
    end else if (grant_now) begin
      grant_q   <= pick;
      we_q      <= sel_we;
      addr_lo_q <= sel_addr[1:0];
      size_q    <= sel_size;
      sext_q    <= sel_sext;
      err_q     <= sel_mis;
      rdata_q   <= '0;
      // Memory-facing fields only move for accesses that will actually be issued
      if (!sel_mis) begin
        dm_addr_q <= {sel_addr[ADDR_W-1:2], 2'b00};
        dm_din_q  <= sel_rep;
        pc_q      <= sel_pc;
      end
    end else if (state_q == StAccess) begin
      rdata_q <= we_q ? '0 : load_val;
    end
  end

  // Memory strobes and requester responses
  always_comb begin
    dm_address = dm_addr_q;
    dm_data_in = dm_din_q;
    pc_now     = pc_q;
    dm_write   = (state_q == StAccess) && we_q;
    BE         = 4'b0000;
    if (state_q == StAccess) begin
      unique case (size_q)
        2'b00:   BE = 4'b0001 << addr_lo_q;
        2'b01:   BE = addr_lo_q[1] ? 4'b1100 : 4'b0011;
        default: BE = 4'b1111;
      endcase
    end
    m0_ack   = (state_q == StDone) && !grant_q;
    m1_ack   = (state_q == StDone) && grant_q;
    m0_err   = m0_ack && err_q;
    m1_err   = m1_ack && err_q;
    m0_rdata = m0_ack ? rdata_q : '0;
    m1_rdata = m1_ack ? rdata_q : '0;
  end

endmodule
